// File: rtl/vga_timing_gen.sv
// VGA display timing: divides clk to the pixel rate, scans column/row, and emits video_on and
// hsync/vsync delayed to line up with the downstream pixel lookup and registered colorizer.
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter int   CLK_DIV   = 4,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   VID_DELAY = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       pix_tick,
  output logic [9:0] pixel_column,
  output logic [9:0] pixel_row,
  output logic       video_on,
  output logic       horiz_sync,
  output logic       vert_sync,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SYNC_STAGES = VID_DELAY + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       SYNC_IDLE = ~SYNC_POL;

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [9:0]       col_q, col_d, row_q, row_d;
  logic             col_wrap, row_wrap, active, hs_raw, vs_raw;

  // {hsync, vsync} per stage; stage 0 samples the live counters
  logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;

  assign col_wrap = (col_q == H_LAST);
  assign row_wrap = (row_q == V_LAST);
  assign active   = (col_q < H_ACT) && (row_q < V_ACT);
  assign hs_raw   = (col_q >= HS_FIRST) && (col_q <= HS_LAST);
  assign vs_raw   = (row_q >= VS_FIRST) && (row_q <= VS_LAST);

  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    tick_d = (div_q == DIV_LAST);
    col_d  = col_q;
    row_d  = row_q;
    if (tick_q) begin
      col_d = col_wrap ? '0 : col_q + 10'd1;
      if (col_wrap) row_d = row_wrap ? '0 : row_q + 10'd1;
    end
  end

  always_comb begin
    sync_d[0] = {(hs_raw ? SYNC_POL : SYNC_IDLE), (vs_raw ? SYNC_POL : SYNC_IDLE)};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= {2{SYNC_IDLE}};
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      col_q  <= col_d;
      row_q  <= row_d;
      sync_q <= sync_d;
    end
  end

  generate
    if (VID_DELAY == 0) begin : g_vid_comb
      // counters sit at (0,0) in reset, so gate to keep video_on low there
      assign video_on = active & reset_n;
    end else begin : g_vid_pipe
      logic [VID_DELAY-1:0] vid_pipe_q, vid_pipe_d;
      always_comb begin
        vid_pipe_d[0] = active;
        for (int i = 1; i < VID_DELAY; i++) vid_pipe_d[i] = vid_pipe_q[i-1];
      end
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vid_pipe_q <= '0;
        else          vid_pipe_q <= vid_pipe_d;
      end
      assign video_on = vid_pipe_q[VID_DELAY-1];
    end
  endgenerate

  assign pix_tick     = tick_q;
  assign pixel_column = col_q;
  assign pixel_row    = row_q;
  assign horiz_sync   = sync_q[SYNC_STAGES-1][1];
  assign vert_sync    = sync_q[SYNC_STAGES-1][0];
  assign frame_start  = tick_q & col_wrap & row_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size timing on one line, plus small-geometry instances compared
// against closed-form position formulas over whole frames.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst1_n, rst2_n;
  logic pt0, vid0, hs0, vs0, fs0; logic [9:0] col0, row0;
  logic pt1, vid1, hs1, vs1, fs1; logic [9:0] col1, row1;
  logic pt2, vid2, hs2, vs2, fs2; logic [9:0] col2, row2;

  int n_cmp = 0;
  int n_bad = 0;
  int e0 = 0;

  // full 640x480 timing, CLK_DIV=4, VID_DELAY=1, active-low syncs
  vga_timing_gen u_d0 (
    .clk(clk), .reset_n(rst0_n), .pix_tick(pt0), .pixel_column(col0), .pixel_row(row0),
    .video_on(vid0), .horiz_sync(hs0), .vert_sync(vs0), .frame_start(fs0));

  // tiny 12x7 geometry, one pixel per clk, active-high syncs, 2-clk video delay
  vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .CLK_DIV(1), .SYNC_POL(1'b1), .VID_DELAY(2)) u_d1 (
    .clk(clk), .reset_n(rst1_n), .pix_tick(pt1), .pixel_column(col1), .pixel_row(row1),
    .video_on(vid1), .horiz_sync(hs1), .vert_sync(vs1), .frame_start(fs1));

  // same geometry, CLK_DIV=3, combinational video_on, active-low syncs
  vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .CLK_DIV(3), .SYNC_POL(1'b0), .VID_DELAY(0)) u_d2 (
    .clk(clk), .reset_n(rst2_n), .pix_tick(pt2), .pixel_column(col2), .pixel_row(row2),
    .video_on(vid2), .horiz_sync(hs2), .vert_sync(vs2), .frame_start(fs2));

  // ticks consumed by the counters after the k-th clk edge following release
  function automatic int pos(int k, int div);
    if (k < 1) return 0;
    return (k - 1) / div;
  endfunction
  function automatic logic act_s(int p);
    int c = p % 12; int r = (p / 12) % 7;
    return (c < 8) && (r < 4);
  endfunction
  function automatic logic hraw_s(int p);
    int c = p % 12;
    return (c >= 9) && (c <= 10);
  endfunction
  function automatic logic vraw_s(int p);
    int r = (p / 12) % 7;
    return r == 5;
  endfunction

  task automatic test_reset();
    rst0_n = 1'b0; rst1_n = 1'b0; rst2_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (pt0 !== 1'b0)   begin n_bad++; $display("FAIL rst_tick0 got %b exp 0", pt0); end
    n_cmp++; if (col0 !== 10'd0) begin n_bad++; $display("FAIL rst_col0 got %0d exp 0", col0); end
    n_cmp++; if (row0 !== 10'd0) begin n_bad++; $display("FAIL rst_row0 got %0d exp 0", row0); end
    n_cmp++; if (vid0 !== 1'b0)  begin n_bad++; $display("FAIL rst_vid0 got %b exp 0", vid0); end
    n_cmp++; if (hs0 !== 1'b1)   begin n_bad++; $display("FAIL rst_hs0 got %b exp 1", hs0); end
    n_cmp++; if (vs0 !== 1'b1)   begin n_bad++; $display("FAIL rst_vs0 got %b exp 1", vs0); end
    n_cmp++; if (fs0 !== 1'b0)   begin n_bad++; $display("FAIL rst_fs0 got %b exp 0", fs0); end
    n_cmp++; if (hs1 !== 1'b0)   begin n_bad++; $display("FAIL rst_hs1 got %b exp 0", hs1); end
    n_cmp++; if (vs1 !== 1'b0)   begin n_bad++; $display("FAIL rst_vs1 got %b exp 0", vs1); end
    n_cmp++; if (vid2 !== 1'b0)  begin n_bad++; $display("FAIL rst_vid2 got %b exp 0", vid2); end
  endtask

  task automatic test_release();
    rst0_n = 1'b1;
    e0 = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1; e0++;
      n_cmp++;
      if (pt0 !== (e0 == 4)) begin n_bad++; $display("FAIL rel_tick e=%0d got %b exp %b", e0, pt0, (e0 == 4)); end
      n_cmp++;
      if (vid0 !== 1'b1) begin n_bad++; $display("FAIL rel_vid e=%0d got %b exp 1", e0, vid0); end
    end
    n_cmp++; if (col0 !== 10'd1) begin n_bad++; $display("FAIL rel_col got %0d exp 1", col0); end
    n_cmp++; if (row0 !== 10'd0) begin n_bad++; $display("FAIL rel_row got %0d exp 0", row0); end
  endtask

  task automatic test_line();
    int e_c656 = -1; int e_hsf = -1; int c_hsf = -1; int e_hsr = -1; int e_vf = -1;
    int e_r1 = -1; int c_r1 = -1; int hs_low = 0; int ticks = 0; int fs_n = 0; int vs_low = 0;
    for (int k = 0; k < 3210; k++) begin
      @(posedge clk); #1; e0++;
      if (e0 <= 3205 && pt0) ticks++;
      if (col0 == 10'd656 && e_c656 < 0) e_c656 = e0;
      if (!hs0) begin
        hs_low++;
        if (e_hsf < 0) begin e_hsf = e0; c_hsf = int'(col0); end
      end else if (e_hsf >= 0 && e_hsr < 0) e_hsr = e0;
      if (!vid0 && e_vf < 0) e_vf = e0;
      if (row0 == 10'd1 && e_r1 < 0) begin e_r1 = e0; c_r1 = int'(col0); end
      if (fs0) fs_n++;
      if (!vs0) vs_low++;
    end
    n_cmp++; if (e_c656 != 2625) begin n_bad++; $display("FAIL line_col656_edge got %0d exp 2625", e_c656); end
    n_cmp++; if (e_hsf != 2627)  begin n_bad++; $display("FAIL line_hs_fall_edge got %0d exp 2627", e_hsf); end
    n_cmp++; if (c_hsf != 656)   begin n_bad++; $display("FAIL line_hs_fall_col got %0d exp 656", c_hsf); end
    n_cmp++; if (e_hsr != 3011)  begin n_bad++; $display("FAIL line_hs_rise_edge got %0d exp 3011", e_hsr); end
    n_cmp++; if (hs_low != 384)  begin n_bad++; $display("FAIL line_hs_low_clks got %0d exp 384", hs_low); end
    n_cmp++; if (e_vf != 2562)   begin n_bad++; $display("FAIL line_vid_fall_edge got %0d exp 2562", e_vf); end
    n_cmp++; if (e_r1 != 3201)   begin n_bad++; $display("FAIL line_period_edge got %0d exp 3201", e_r1); end
    n_cmp++; if (c_r1 != 0)      begin n_bad++; $display("FAIL line_wrap_col got %0d exp 0", c_r1); end
    n_cmp++; if (ticks != 800)   begin n_bad++; $display("FAIL line_ticks got %0d exp 800", ticks); end
    n_cmp++; if (fs_n != 0)      begin n_bad++; $display("FAIL line_fs_count got %0d exp 0", fs_n); end
    n_cmp++; if (vs_low != 0)    begin n_bad++; $display("FAIL line_vs_low got %0d exp 0", vs_low); end
  endtask

  task automatic test_midline_reset();
    int found = 0;
    for (int k = 0; k < 2000 && found == 0; k++) begin
      @(posedge clk); #1; e0++;
      if (row0 == 10'd1 && col0 == 10'd400) found = 1;
    end
    n_cmp++; if (found != 1) begin n_bad++; $display("FAIL mid_reach got %0d exp 1", found); end
    n_cmp++; if (e0 != 4801) begin n_bad++; $display("FAIL mid_reach_edge got %0d exp 4801", e0); end
    #2 rst0_n = 1'b0;
    #1;
    n_cmp++; if (col0 !== 10'd0) begin n_bad++; $display("FAIL mid_col got %0d exp 0", col0); end
    n_cmp++; if (row0 !== 10'd0) begin n_bad++; $display("FAIL mid_row got %0d exp 0", row0); end
    n_cmp++; if (vid0 !== 1'b0)  begin n_bad++; $display("FAIL mid_vid got %b exp 0", vid0); end
    n_cmp++; if (hs0 !== 1'b1 || vs0 !== 1'b1) begin n_bad++; $display("FAIL mid_sync got %b%b exp 11", hs0, vs0); end
    n_cmp++; if (pt0 !== 1'b0 || fs0 !== 1'b0) begin n_bad++; $display("FAIL mid_pulse got %b%b exp 00", pt0, fs0); end
    repeat (2) @(posedge clk);
    #1 rst0_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (pt0 !== 1'b1 || col0 !== 10'd0) begin n_bad++; $display("FAIL mid_first_tick got %b/%0d exp 1/0", pt0, col0); end
    @(posedge clk); #1;
    n_cmp++; if (col0 !== 10'd1 || row0 !== 10'd0) begin n_bad++; $display("FAIL mid_restart got %0d,%0d exp 1,0", col0, row0); end
  endtask

  task automatic test_small_exhaustive();
    int fs1_n = 0; int fs2_n = 0; int vid1_n = 0;
    rst1_n = 1'b1; rst2_n = 1'b1;
    for (int e = 1; e <= 280; e++) begin
      int p1; int p2; logic xfs1; logic xvid1; logic xhs1; logic xvs1;
      logic xt2; logic xfs2; logic xvid2; logic xhs2; logic xvs2;
      @(posedge clk); #1;
      p1    = pos(e, 1);
      xfs1  = (p1 % 12 == 11) && ((p1 / 12) % 7 == 6);
      xvid1 = (e >= 2) ? act_s(pos(e - 2, 1)) : 1'b0;
      xhs1  = (e >= 3) ? hraw_s(pos(e - 3, 1)) : 1'b0;
      xvs1  = (e >= 3) ? vraw_s(pos(e - 3, 1)) : 1'b0;
      p2    = pos(e, 3);
      xt2   = (e % 3 == 0);
      xfs2  = xt2 && (p2 % 12 == 11) && ((p2 / 12) % 7 == 6);
      xvid2 = act_s(p2);
      xhs2  = ~hraw_s(pos(e - 1, 3));
      xvs2  = ~vraw_s(pos(e - 1, 3));
      n_cmp++; if (pt1 !== 1'b1) begin n_bad++; $display("FAIL s1_tick e=%0d got %b exp 1", e, pt1); end
      n_cmp++; if (col1 !== 10'(p1 % 12)) begin n_bad++; $display("FAIL s1_col e=%0d got %0d exp %0d", e, col1, p1 % 12); end
      n_cmp++; if (row1 !== 10'((p1 / 12) % 7)) begin n_bad++; $display("FAIL s1_row e=%0d got %0d exp %0d", e, row1, (p1 / 12) % 7); end
      n_cmp++; if (fs1 !== xfs1) begin n_bad++; $display("FAIL s1_fs e=%0d got %b exp %b", e, fs1, xfs1); end
      n_cmp++; if (vid1 !== xvid1) begin n_bad++; $display("FAIL s1_vid e=%0d got %b exp %b", e, vid1, xvid1); end
      n_cmp++; if (hs1 !== xhs1) begin n_bad++; $display("FAIL s1_hs e=%0d got %b exp %b", e, hs1, xhs1); end
      n_cmp++; if (vs1 !== xvs1) begin n_bad++; $display("FAIL s1_vs e=%0d got %b exp %b", e, vs1, xvs1); end
      n_cmp++; if (pt2 !== xt2) begin n_bad++; $display("FAIL s2_tick e=%0d got %b exp %b", e, pt2, xt2); end
      n_cmp++; if (col2 !== 10'(p2 % 12)) begin n_bad++; $display("FAIL s2_col e=%0d got %0d exp %0d", e, col2, p2 % 12); end
      n_cmp++; if (row2 !== 10'((p2 / 12) % 7)) begin n_bad++; $display("FAIL s2_row e=%0d got %0d exp %0d", e, row2, (p2 / 12) % 7); end
      n_cmp++; if (fs2 !== xfs2) begin n_bad++; $display("FAIL s2_fs e=%0d got %b exp %b", e, fs2, xfs2); end
      n_cmp++; if (vid2 !== xvid2) begin n_bad++; $display("FAIL s2_vid e=%0d got %b exp %b", e, vid2, xvid2); end
      n_cmp++; if (hs2 !== xhs2) begin n_bad++; $display("FAIL s2_hs e=%0d got %b exp %b", e, hs2, xhs2); end
      n_cmp++; if (vs2 !== xvs2) begin n_bad++; $display("FAIL s2_vs e=%0d got %b exp %b", e, vs2, xvs2); end
      if (fs1) fs1_n++;
      if (fs2) fs2_n++;
      if (e >= 3 && e <= 86 && vid1) vid1_n++;
    end
    n_cmp++; if (fs1_n != 3)   begin n_bad++; $display("FAIL s1_fs_count got %0d exp 3", fs1_n); end
    n_cmp++; if (fs2_n != 1)   begin n_bad++; $display("FAIL s2_fs_count got %0d exp 1", fs2_n); end
    n_cmp++; if (vid1_n != 32) begin n_bad++; $display("FAIL s1_vid_per_frame got %0d exp 32", vid1_n); end
  endtask

  task automatic test_small_reset();
    // both small instances sit mid-frame (row 2 / row 0 of frame 2) here
    #2 rst1_n = 1'b0; rst2_n = 1'b0;
    #1;
    n_cmp++; if (col1 !== 10'd0 || row1 !== 10'd0) begin n_bad++; $display("FAIL sr_pos1 got %0d,%0d exp 0,0", col1, row1); end
    n_cmp++; if (pt1 !== 1'b0 || fs1 !== 1'b0 || vid1 !== 1'b0) begin n_bad++; $display("FAIL sr_out1 got %b%b%b exp 000", pt1, fs1, vid1); end
    n_cmp++; if (hs1 !== 1'b0 || vs1 !== 1'b0) begin n_bad++; $display("FAIL sr_sync1 got %b%b exp 00", hs1, vs1); end
    n_cmp++; if (vid2 !== 1'b0 || hs2 !== 1'b1 || vs2 !== 1'b1) begin n_bad++; $display("FAIL sr_out2 got %b%b%b exp 011", vid2, hs2, vs2); end
    repeat (2) @(posedge clk);
    #1 rst1_n = 1'b1; rst2_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (pt1 !== 1'b1 || col1 !== 10'd0) begin n_bad++; $display("FAIL sr_tick1 got %b/%0d exp 1/0", pt1, col1); end
    @(posedge clk); #1;
    n_cmp++; if (col1 !== 10'd1 || row1 !== 10'd0) begin n_bad++; $display("FAIL sr_restart1 got %0d,%0d exp 1,0", col1, row1); end
    @(posedge clk); #1;
    n_cmp++; if (pt2 !== 1'b1 || col2 !== 10'd0) begin n_bad++; $display("FAIL sr_tick2 got %b/%0d exp 1/0", pt2, col2); end
    @(posedge clk); #1;
    n_cmp++; if (col2 !== 10'd1 || row2 !== 10'd0) begin n_bad++; $display("FAIL sr_restart2 got %0d,%0d exp 1,0", col2, row2); end
  endtask

  initial begin
    test_reset();
    test_release();
    test_line();
    test_midline_reset();
    test_small_exhaustive();
    test_small_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
